// File: rtl/rcpu_dbg_pkg.sv
// Shared types for the RCPU run/step controller: FSM state codes and LED source selects.
package rcpu_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STEP     = 3'd1,
        WAIT_REL = 3'd2,
        RUN      = 3'd3,
        HALTED   = 3'd4
    } state_e;

    localparam logic [1:0] LED_PC     = 2'd0;
    localparam logic [1:0] LED_ALU_LO = 2'd1;
    localparam logic [1:0] LED_ALU_HI = 2'd2;
    localparam logic [1:0] LED_ICNT   = 2'd3;

endpackage

// File: rtl/rcpu_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stability counter, debounced level and press pulse.
module rcpu_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic btn_db_o,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             btn_db_q;
    logic             db_prev_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // The press pulse is registered off the debounced level, so it lags the rising edge of btn_db by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            btn_db_q  <= 1'b0;
            db_prev_q <= 1'b0;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            db_prev_q <= btn_db_q;
            press_q   <= btn_db_q & ~db_prev_q;
            if (sync2_q != btn_db_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db_q <= sync2_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign btn_db_o = btn_db_q;
    assign press_o  = press_q;

endmodule

// File: rtl/rcpu_step_ctrl.sv
// Run/step controller generating the CPU clock enable and the LED debug mux.
// Optional breakpoint compare is enabled by defining RCPU_BREAKPOINT_EN.
module rcpu_step_ctrl
    import rcpu_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PC_W            = 8,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_btn,
    input  logic [2:0]        SW,
    input  logic [PC_W-1:0]   cpu_pc,
    input  logic [DATA_W-1:0] cpu_alu,
    input  logic              cpu_halt,
    input  logic [PC_W-1:0]   bp_addr,
    output logic              cpu_ce,
    output logic [7:0]        LED,
    output logic [2:0]        state_o
);

    state_e     state_q;
    logic       run_first_q;
    logic [7:0] icount_q;
    logic [7:0] led_q;
    logic       btn_db;
    logic       press;
    logic       bp_hit;
    logic       unused_inputs;

    rcpu_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (step_btn),
        .btn_db_o(btn_db),
        .press_o (press)
    );

    // A run that starts on the breakpoint address must be allowed to leave it, so the first RUN cycle masks the hit.
`ifdef RCPU_BREAKPOINT_EN
    assign bp_hit        = (cpu_pc == bp_addr) && !run_first_q;
    assign unused_inputs = ^{cpu_alu, cpu_pc};
`else
    assign bp_hit        = 1'b0;
    assign unused_inputs = ^{cpu_alu, cpu_pc, bp_addr, run_first_q};
`endif

    always_comb begin
        cpu_ce = 1'b0;
        case (state_q)
            STEP:    cpu_ce = 1'b1;
            RUN:     cpu_ce = SW[2] && !cpu_halt && !bp_hit;
            default: cpu_ce = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            run_first_q <= 1'b0;
        end else begin
            run_first_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (SW[2]) begin
                        state_q     <= RUN;
                        run_first_q <= 1'b1;
                    end else if (press) begin
                        state_q <= STEP;
                    end
                end
                STEP:     state_q <= WAIT_REL;
                WAIT_REL: if (!btn_db) state_q <= IDLE;
                RUN: begin
                    if (!SW[2]) begin
                        state_q <= IDLE;
                    end else if (cpu_halt || bp_hit) begin
                        state_q <= HALTED;
                    end
                end
                HALTED:   if (!SW[2]) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icount_q <= 8'd0;
            led_q    <= 8'd0;
        end else begin
            if (cpu_ce) begin
                icount_q <= icount_q + 8'd1;
            end
            case (SW[1:0])
                LED_PC:     led_q <= cpu_pc[7:0];
                LED_ALU_LO: led_q <= cpu_alu[7:0];
                LED_ALU_HI: led_q <= cpu_alu[15:8];
                default:    led_q <= icount_q;
            endcase
        end
    end

    assign LED     = led_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_rcpu_step_ctrl.sv
// Scoreboard bench for rcpu_step_ctrl: expected cpu_ce pulse cycles and LED values are queued and checked by monitors.
module tb_rcpu_step_ctrl;
    import rcpu_dbg_pkg::*;

    localparam int DB = 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        step_btn = 1'b0;
    logic        cpu_halt = 1'b0;
    logic [2:0]  SW       = 3'b000;
    logic [7:0]  cpu_pc;
    logic [31:0] cpu_alu  = 32'd0;
    logic [7:0]  bp_addr  = 8'd0;
    logic        cpu_ce;
    logic [7:0]  LED;
    logic [2:0]  state_o;

    logic [7:0]  cpuPc = 8'd0;
    int          cyc = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    int          pulseQ[$];
    logic [7:0]  ledQ[$];
    bit          expCeAt[int];
    int          modelIcount = 0;
    bit          randomSel = 1'b0;
    bit          randomHalt = 1'b0;

    assign cpu_pc = cpuPc;

    rcpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .PC_W           (8),
        .DATA_W         (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .step_btn(step_btn),
        .SW      (SW),
        .cpu_pc  (cpu_pc),
        .cpu_alu (cpu_alu),
        .cpu_halt(cpu_halt),
        .bp_addr (bp_addr),
        .cpu_ce  (cpu_ce),
        .LED     (LED),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in CPU: the PC advances on every enabled cycle.
    always @(posedge clk) begin
        if (cpu_ce === 1'b1) cpuPc <= cpuPc + 8'd1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ledModel(input logic [1:0] sel, input logic [7:0] pc,
                                            input logic [31:0] alu, input int icnt);
        case (sel)
            2'd0:    return pc;
            2'd1:    return alu[7:0];
            2'd2:    return alu[15:8];
            default: return 8'(icnt % 256);
        endcase
    endfunction

    task automatic schedule(input int at);
        pulseQ.push_back(at);
        expCeAt[at] = 1'b1;
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cpu_alu = $urandom;
            if (randomSel) SW[1:0] = 2'($urandom);
            if (randomHalt) cpu_halt = 1'($urandom);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(1);
    endtask

    // A press sampled on the next edge yields one enable pulse DB+3 edges later.
    task automatic doStep(input int hold);
        int c = cyc;
        schedule(c + DB + 4);
        step_btn = 1'b1;
        applyStimulus(hold);
        step_btn = 1'b0;
        applyStimulus(DB + 5 + int'($urandom_range(0, 3)));
    endtask

    // Enable monitor: each pulse must match the next scheduled cycle.
    always @(negedge clk) begin
        if (pulseQ.size() > 0 && pulseQ[0] == cyc) begin
            void'(pulseQ.pop_front());
            checkOutput("cePulse", {31'd0, cpu_ce}, 32'd1);
        end else if (cpu_ce === 1'b1) begin
            checkOutput("ceUnexpected", {31'd0, cpu_ce}, 32'd0);
        end
    end

    // LED monitor: predicts next cycle's display from this cycle's inputs and the modelled count.
    always @(negedge clk) begin
        if (ledQ.size() > 0) checkOutput("led", {24'd0, LED}, {24'd0, ledQ.pop_front()});
        if (rst) begin
            ledQ.push_back(8'h00);
            modelIcount = 0;
        end else begin
            ledQ.push_back(ledModel(SW[1:0], cpu_pc, cpu_alu, modelIcount));
            if (expCeAt.exists(cyc)) modelIcount++;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         c;
        logic [7:0] p;

        applyStimulus(3);
        checkOutput("resetState", {29'd0, state_o}, {29'd0, IDLE});
        checkOutput("resetLed", {24'd0, LED}, 32'd0);
        checkOutput("resetCe", {31'd0, cpu_ce}, 32'd0);
        rst = 1'b0;
        applyStimulus(2);

        doStep(20);
        SW[1:0] = 2'b11;
        applyStimulus(2);
        checkOutput("icountAfterStep", {24'd0, LED}, 32'd1);
        SW = 3'b000;

        for (int i = 0; i < 20; i++) begin
            step_btn = ((i / 2) % 2) == 0;
            applyStimulus(1);
        end
        step_btn = 1'b0;
        applyStimulus(DB + 6);
        checkOutput("bounceIdle", {29'd0, state_o}, {29'd0, IDLE});

        resetDut();
        SW = 3'b011;
`ifdef RCPU_BREAKPOINT_EN
        bp_addr = cpuPc + 8'd100;
`else
        bp_addr = cpuPc + 8'd3;
`endif
        c = cyc;
        for (int k = 1; k <= 10; k++) schedule(c + k);
        SW = 3'b111;
        applyStimulus(11);
        cpu_halt = 1'b1;
        applyStimulus(1);
        checkOutput("haltState", {29'd0, state_o}, {29'd0, HALTED});
        checkOutput("haltIcount", {24'd0, LED}, 32'd10);
        SW = 3'b011;
        applyStimulus(1);
        checkOutput("haltToIdle", {29'd0, state_o}, {29'd0, IDLE});
        cpu_halt = 1'b0;

`ifdef RCPU_BREAKPOINT_EN
        p = cpuPc;
        bp_addr = p + 8'd5;
        c = cyc;
        for (int k = 1; k <= 5; k++) schedule(c + k);
        SW = 3'b111;
        applyStimulus(7);
        checkOutput("bpState", {29'd0, state_o}, {29'd0, HALTED});
        checkOutput("bpPc", {24'd0, cpu_pc}, {24'd0, 8'(p + 8'd5)});
        SW = 3'b011;
        applyStimulus(1);
        checkOutput("bpIdle", {29'd0, state_o}, {29'd0, IDLE});
        c = cyc;
        for (int k = 1; k <= 4; k++) schedule(c + k);
        SW = 3'b111;
        applyStimulus(5);
        SW = 3'b011;
        checkOutput("bpResumePc", {24'd0, cpu_pc}, {24'd0, 8'(p + 8'd9)});
        applyStimulus(1);
        checkOutput("bpResumeIdle", {29'd0, state_o}, {29'd0, IDLE});
`else
        p = cpuPc;
        bp_addr = p + 8'd3;
        c = cyc;
        for (int k = 1; k <= 8; k++) schedule(c + k);
        SW = 3'b111;
        applyStimulus(9);
        SW = 3'b011;
        checkOutput("bpIgnoredPc", {24'd0, cpu_pc}, {24'd0, 8'(p + 8'd8)});
        applyStimulus(1);
        checkOutput("bpIgnoredIdle", {29'd0, state_o}, {29'd0, IDLE});
`endif

        c = cyc;
        for (int k = 1; k <= 6; k++) schedule(c + k);
        SW = 3'b111;
        applyStimulus(6);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("midRunRstCe", {31'd0, cpu_ce}, 32'd0);
        checkOutput("midRunRstLed", {24'd0, LED}, 32'd0);
        checkOutput("midRunRstState", {29'd0, state_o}, {29'd0, IDLE});
        rst = 1'b0;
        SW = 3'b011;
        applyStimulus(1);

        resetDut();
        randomSel  = 1'b1;
        randomHalt = 1'b1;
        for (int s = 0; s < 256; s++) doStep(int'($urandom_range(DB, DB + 12)));
        randomSel  = 1'b0;
        randomHalt = 1'b0;
        cpu_halt   = 1'b0;
        SW         = 3'b011;
        applyStimulus(2);
        checkOutput("wrapIcount", {24'd0, LED}, 32'd0);
        checkOutput("wrapState", {29'd0, state_o}, {29'd0, IDLE});

        applyStimulus(2);
        checkOutput("pendingPulses", pulseQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/rcpu_step_ctrl.md
# rcpu_step_ctrl

Run/step controller for the RCPU board top. It sits between the board switches and pushbutton and the CPU core, and generates the core's clock-enable `cpu_ce` in single-step, free-run, halt and breakpoint modes. It also multiplexes CPU debug state onto the 8 board LEDs. The core runs on the same `clk`; it advances one instruction per cycle in which `cpu_ce` is 1.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before the debounced button level changes; must be ≥1.
- `PC_W`, 8: CPU PC width; must be ≥8.
- `DATA_W`, 32: CPU ALU result width; must be ≥16.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `step_btn` in 1: raw, asynchronous pushbutton.
- `SW` in 3: `SW[2]` selects mode (1 = run, 0 = step); `SW[1:0]` selects the LED source.
- `cpu_pc` in PC_W: current CPU PC.
- `cpu_alu` in DATA_W: current ALU result.
- `cpu_halt` in 1: the CPU is executing its halt instruction.
- `bp_addr` in PC_W: breakpoint address; used only with `RCPU_BREAKPOINT_EN`.
- `cpu_ce` out 1: CPU clock enable (combinational from state and inputs); reset 0.
- `LED` out 8: registered debug display; reset 0.
- `state_o` out 3: current FSM state code; reset IDLE.

## Operation
- Debounce path:
  - `step_btn` passes through a 2-flop synchronizer, then a counter.
  - The debounced level `btn_db` takes the synchronized value after it has differed from `btn_db` for exactly `DEBOUNCE_CYCLES` consecutive cycles. Any bounce clears the counter.
  - `press` is a one-cycle pulse on each rising edge of `btn_db`.
- FSM states: IDLE=0, STEP=1, WAIT_REL=2, RUN=3, HALTED=4. Transitions:
  - IDLE: if `SW[2]`=1, go to RUN. Otherwise, if `press`, go to STEP. When `SW[2]`=1 and `press` occur together, RUN wins.
  - STEP: `cpu_ce`=1 for exactly this one cycle, then go to WAIT_REL.
  - WAIT_REL: go to IDLE when `btn_db`=0. `SW[2]` is ignored until then.
  - RUN:
    - `cpu_ce` = !`cpu_halt` && !`bp_hit`.
    - If `SW[2]`=0, go to IDLE. This has the highest priority.
    - Else, if `cpu_halt` or `bp_hit`, go to HALTED.
    - `press` is ignored.
  - HALTED: `cpu_ce`=0; go to IDLE when `SW[2]`=0.
- `bp_hit` = (`cpu_pc` == `bp_addr`), but it is forced to 0 in the first cycle after entering RUN. This lets a run resume from the breakpoint address.
- Instruction counter:
  - 8-bit `icount` increments on every cycle with `cpu_ce`=1.
  - Wraps 255 → 0.
  - Reset value 0.
- LED source, selected by `SW[1:0]`:
  - 00: `cpu_pc[7:0]`
  - 01: `cpu_alu[7:0]`
  - 10: `cpu_alu[15:8]`
  - 11: `icount`
- Stepping from IDLE is permitted while `cpu_halt`=1; the CPU re-executes its halt instruction.

## Timing
- `rst` asserted: on the next edge, state becomes IDLE and the synchronizer, `btn_db`, debounce counter, `icount` and `LED` all clear to 0. `cpu_ce` is 0 in the cycle after reset.
- Reset mid-operation aborts any step or run immediately. If the button is held through reset, it registers as a new press `DEBOUNCE_CYCLES`+2 cycles after `rst` deasserts.
- Button latency: when the first clock edge samples `step_btn`=1 at edge 0 and the button stays stable, `cpu_ce` pulses in the cycle following edge `DEBOUNCE_CYCLES`+3.
- `LED` has 1-cycle latency from `SW[1:0]`, `cpu_pc`, `cpu_alu` and `icount`.
- Mode switch: `SW[2]` 1→0 in RUN drops `cpu_ce` combinationally in the same cycle.

## Configuration
- `RCPU_BREAKPOINT_EN` defined: `bp_addr` compare is active as described above.
- Not defined: the `bp_addr` port is still present but ignored, and `bp_hit` is constant 0. RUN leaves only on `cpu_halt` or `SW[2]`=0.

## Structure
- Package `rcpu_dbg_pkg` holds:
  - the FSM state enum (3-bit, with the codes above);
  - LED select constants `LED_PC`, `LED_ALU_LO`, `LED_ALU_HI`, `LED_ICNT`.
- Sub-module `rcpu_debounce` (synchronizer, counter, `btn_db`, `press`), parameterized by `DEBOUNCE_CYCLES`.

## Test plan
- Step: `DEBOUNCE_CYCLES`=4, `SW`=000, hold `step_btn` for 20 cycles, then release → exactly one `cpu_ce` pulse, 7 cycles after the first sampled press; `icount`=1 (visible with `SW[1:0]`=11).
- Bounce: toggle `step_btn` every 2 cycles for 20 cycles, then hold low → no `cpu_ce` pulse; state stays IDLE.
- Run/halt: `SW[2]`=1 → `cpu_ce`=1 each cycle. Assert `cpu_halt` at cycle 10 → `cpu_ce`=0 that cycle, state HALTED; `icount`=10 (pulses in cycles 0–9 after `cpu_ce` first asserts). Set `SW[2]`=0 → IDLE.
- Breakpoint (macro on): `bp_addr`=0x05, PC model increments on `cpu_ce` → halts with `cpu_pc`=0x05. Re-enter RUN at PC 5 → the first cycle has `cpu_ce`=1; PC reaches 6.
- Wrap: 256 steps from reset → `icount`=0x00; `LED`=0x00 with `SW[1:0]`=11.
- Reset mid-RUN: assert `rst` for 1 cycle → `cpu_ce`=0, `LED`=0, `state_o`=0 on the next cycle.
